ymux4_operand_bank: RTL and testbench

Four-entry operand register bank and select sequencer that sits directly upstream of the 32-bit four-to-one mux (`yMux4to1`). It drives the mux data inputs `a0`–`a3` and the 2-bit select `c`. Operands are loaded through a valid/ready write port. On `start`, the bank holds its data stable and steps `c` through 0..3, one value per cycle, so the downstream stage sees each operand on `z` in turn.

---
 rtl/ymux4_operand_bank.sv | 136 +++++++++++++
 tb/tb_ymux4_operand_bank.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ymux4_operand_bank.sv
// ymux4_operand_bank: four-entry operand bank feeding a 4:1 mux, with a
// valid/ready write port and a start-triggered select scan (c = 0..3).
`default_nettype none

module ymux4_operand_bank #(
   parameter int SIZE = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            wr_valid,
   output logic            wr_ready,
   input  logic [1:0]      wr_addr,
   input  logic [SIZE-1:0] wr_data,
   input  logic            start,
   output logic            busy,
   output logic [SIZE-1:0] a0,
   output logic [SIZE-1:0] a1,
   output logic [SIZE-1:0] a2,
   output logic [SIZE-1:0] a3,
   output logic [1:0]      c,
   output logic            sel_valid,
   output logic            done,
   output logic            err,
   output logic [3:0]      loaded
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SCAN = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]      state_q, state_d;
   logic            arm_q, arm_d;
   logic [1:0]      c_q, c_d;
   logic            sel_valid_q, sel_valid_d;
   logic            done_q, done_d;
   logic            err_q, err_d;
   logic            busy_q, busy_d;
   logic [3:0]      loaded_q, loaded_d;
   logic [SIZE-1:0] entry_q [4];

   logic            wr_accept;
   logic [3:0]      loaded_post;

   assign wr_ready    = (state_q == S_IDLE);
   assign wr_accept   = wr_valid & wr_ready;
   // The start check sees a write landing on the same edge.
   assign loaded_post = loaded_q | (wr_accept ? (4'b0001 << wr_addr) : 4'b0000);

   always_comb begin
      state_d     = state_q;
      arm_d       = arm_q;
      c_d         = c_q;
      sel_valid_d = 1'b0;
      done_d      = 1'b0;
      err_d       = 1'b0;
      loaded_d    = loaded_post;
      case (state_q)
         S_IDLE: begin
            if (arm_q) begin
               state_d     = S_SCAN;
               arm_d       = 1'b0;
               c_d         = 2'd0;
               sel_valid_d = 1'b1;
            end else if (start) begin
               if (&loaded_post) begin
                  arm_d = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_SCAN: begin
            if (c_q == 2'd3) begin
               state_d  = S_DONE;
               c_d      = 2'd0;
               done_d   = 1'b1;
               loaded_d = 4'b0000;
            end else begin
               c_d         = c_q + 2'd1;
               sel_valid_d = 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            arm_d   = 1'b0;
            c_d     = 2'd0;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         arm_q       <= 1'b0;
         c_q         <= 2'd0;
         sel_valid_q <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         busy_q      <= 1'b0;
         loaded_q    <= 4'b0000;
         for (int i = 0; i < 4; i++) begin
            entry_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         arm_q       <= arm_d;
         c_q         <= c_d;
         sel_valid_q <= sel_valid_d;
         done_q      <= done_d;
         err_q       <= err_d;
         busy_q      <= busy_d;
         loaded_q    <= loaded_d;
         if (wr_accept) begin
            entry_q[wr_addr] <= wr_data;
         end
      end
   end

   assign a0        = entry_q[0];
   assign a1        = entry_q[1];
   assign a2        = entry_q[2];
   assign a3        = entry_q[3];
   assign c         = c_q;
   assign sel_valid = sel_valid_q;
   assign done      = done_q;
   assign err       = err_q;
   assign busy      = busy_q;
   assign loaded    = loaded_q;

endmodule

`default_nettype wire

// File: tb/tb_ymux4_operand_bank.sv
// Directed bench for ymux4_operand_bank with a scoreboard of expected mux words.
`default_nettype none

module tb_ymux4_operand_bank;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        wr_valid = 1'b0;
   logic        wr_ready;
   logic [1:0]  wr_addr = 2'd0;
   logic [31:0] wr_data = 32'd0;
   logic        start = 1'b0;
   logic        busy;
   logic [31:0] a0, a1, a2, a3;
   logic [1:0]  c;
   logic        sel_valid, done, err;
   logic [3:0]  loaded;
   logic [31:0] z;

   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] exp_a [4];
   logic [3:0]  exp_loaded;
   logic [31:0] sb_q [$];

   always #5 clk = ~clk;

   ymux4_operand_bank #(.SIZE(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .start(start), .busy(busy),
      .a0(a0), .a1(a1), .a2(a2), .a3(a3),
      .c(c), .sel_valid(sel_valid), .done(done), .err(err), .loaded(loaded)
   );

   // Downstream yMux4to1 stand-in
   always_comb begin
      case (c)
         2'd0:    z = a0;
         2'd1:    z = a1;
         2'd2:    z = a2;
         default: z = a3;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] dut_a(input int i);
      case (i)
         0:       return a0;
         1:       return a1;
         2:       return a2;
         default: return a3;
      endcase
   endfunction

   task automatic check_reset_vals(input string tag);
      chk({tag, "_a0"}, a0, 32'd0);
      chk({tag, "_a1"}, a1, 32'd0);
      chk({tag, "_a2"}, a2, 32'd0);
      chk({tag, "_a3"}, a3, 32'd0);
      chk({tag, "_c"}, {30'd0, c}, 32'd0);
      chk({tag, "_loaded"}, {28'd0, loaded}, 32'd0);
      chk({tag, "_wr_ready"}, {31'd0, wr_ready}, 32'd1);
      chk({tag, "_pulses"}, {28'd0, sel_valid, done, err, busy}, 32'd0);
   endtask

   task automatic wr(input logic [1:0] addr, input logic [31:0] data);
      wr_valid = 1'b1;
      wr_addr  = addr;
      wr_data  = data;
      tick();
      wr_valid = 1'b0;
      exp_a[addr]      = data;
      exp_loaded[addr] = 1'b1;
      chk("wr_data", dut_a(int'(addr)), data);
      chk("wr_loaded", {28'd0, loaded}, {28'd0, exp_loaded});
   endtask

   // Edge N: start accepted; optionally with a same-edge write to entry 3.
   task automatic scan_start(input bit same_wr, input logic [31:0] same_data);
      if (same_wr) begin
         wr_valid = 1'b1;
         wr_addr  = 2'd3;
         wr_data  = same_data;
         exp_a[3] = same_data;
         exp_loaded[3] = 1'b1;
      end
      start = 1'b1;
      for (int i = 0; i < 4; i++) sb_q.push_back(exp_a[i]);
      tick();
      start    = 1'b0;
      wr_valid = 1'b0;
      chk("arm_busy", {31'd0, busy}, 32'd0);
      chk("arm_err", {31'd0, err}, 32'd0);
   endtask

   task automatic scan_body(input bit blocked);
      logic [31:0] want;
      for (int i = 0; i < 4; i++) begin
         tick();
         wr_valid = 1'b0;
         start    = 1'b0;
         want = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hxxxxxxxx;
         chk("scan_c", {30'd0, c}, i);
         chk("scan_sel_valid", {31'd0, sel_valid}, 32'd1);
         chk("scan_busy_done", {30'd0, busy, done}, 32'd2);
         chk("scan_wr_ready", {31'd0, wr_ready}, 32'd0);
         chk("scan_z", z, want);
         if (i == 3) chk("scan_a3", a3, exp_a[3]);
         if (blocked) begin
            chk("blocked_a2", a2, exp_a[2]);
            chk("blocked_err", {31'd0, err}, 32'd0);
            if (i < 3) begin
               wr_valid = 1'b1;
               wr_addr  = 2'd2;
               wr_data  = 32'hDEADBEEF;
               start    = (i == 1);
            end
         end
      end
      tick();
      wr_valid = 1'b0;
      start    = 1'b0;
      exp_loaded = 4'b0000;
      chk("done_pulse", {31'd0, done}, 32'd1);
      chk("done_c", {30'd0, c}, 32'd0);
      chk("done_sel_valid", {31'd0, sel_valid}, 32'd0);
      chk("done_busy", {31'd0, busy}, 32'd1);
      chk("done_loaded", {28'd0, loaded}, 32'd0);
      chk("done_err", {31'd0, err}, 32'd0);
      chk("done_a2", a2, exp_a[2]);
      tick();
      chk("idle_done", {31'd0, done}, 32'd0);
      chk("idle_busy", {31'd0, busy}, 32'd0);
      chk("idle_wr_ready", {31'd0, wr_ready}, 32'd1);
      chk("sb_empty", sb_q.size(), 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 4; i++) exp_a[i] = 32'd0;
      exp_loaded = 4'b0000;

      // Asynchronous reset, checked before any clock edge
      #2 rst_n = 1'b0;
      #1 check_reset_vals("rst_async");
      tick();
      tick();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check_reset_vals("rst_release");

      // Full scan
      wr(2'd0, 32'h11111111);
      wr(2'd1, 32'h22222222);
      wr(2'd2, 32'h33333333);
      wr(2'd3, 32'h44444444);
      scan_start(1'b0, 32'd0);
      scan_body(1'b0);

      // Rejected start with entry 2 missing
      wr(2'd0, 32'h11111111);
      wr(2'd1, 32'h22222222);
      wr(2'd3, 32'h44444444);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("rej_err", {31'd0, err}, 32'd1);
      chk("rej_busy", {31'd0, busy}, 32'd0);
      chk("rej_c", {30'd0, c}, 32'd0);
      chk("rej_loaded", {28'd0, loaded}, 32'h0000000B);
      tick();
      chk("rej_err_1cyc", {31'd0, err}, 32'd0);
      chk("rej_busy_after", {31'd0, busy}, 32'd0);

      // Writes and a second start blocked during scan
      wr(2'd2, 32'h33333333);
      scan_start(1'b0, 32'd0);
      scan_body(1'b1);

      // Same-edge write of entry 3 and start
      wr(2'd0, 32'h11111111);
      wr(2'd1, 32'h22222222);
      wr(2'd2, 32'h33333333);
      scan_start(1'b1, 32'hCAFEF00D);
      chk("same_a3", a3, 32'hCAFEF00D);
      scan_body(1'b0);

      // Reset mid-scan at c == 2
      wr(2'd0, 32'h55555555);
      wr(2'd1, 32'h66666666);
      wr(2'd2, 32'h77777777);
      wr(2'd3, 32'h88888888);
      scan_start(1'b0, 32'd0);
      tick();
      tick();
      tick();
      chk("mid_c", {30'd0, c}, 32'd2);
      #2 rst_n = 1'b0;
      #1 check_reset_vals("rst_mid");
      sb_q.delete();
      for (int i = 0; i < 4; i++) exp_a[i] = 32'd0;
      exp_loaded = 4'b0000;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 7; i++) begin
         tick();
         chk("post_rst_no_done", {30'd0, done, busy}, 32'd0);
      end
      check_reset_vals("post_rst");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
